serial_addsub_ctrl: RTL and testbench

- Controller that sequences a single 1-bit add cell over WIDTH cycles to add or subtract two WIDTH-bit operands, LSB first.
- The cell is a full adder built from two half-adder stages plus a carry register.
- Operands are captured on an input valid/ready handshake; the result is presented on an output valid/ready handshake.
- Used where area matters more than latency and one bit-level adder is shared across all bit positions.

---
 rtl/serial_addsub_ctrl.sv | 120 ++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial adder/subtractor.
// One full-adder cell (two half-adder stages plus a carry register) is
// reused over WIDTH cycles, LSB first, to form A+B or A-B. Operands enter
// on a valid/ready handshake and the result leaves on another one.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index of the last bit; the edge that processes it also completes the result.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry;

  // Shared single-bit cell: two half adders combined into a full adder.
  logic p;
  logic g1;
  logic sum_bit;
  logic g2;
  logic carry_next;

  // Combinational full-adder cell acting on the current LSBs and carry.
  always_comb begin
    p          = a_sh[0] ^ b_sh[0];
    g1         = a_sh[0] & b_sh[0];
    sum_bit    = p ^ carry;
    g2         = p & carry;
    carry_next = g1 | g2;
  end

  // Control FSM with datapath registers; all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      c         <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1; the +1 comes in as the initial carry.
            a_sh     <= a;
            b_sh     <= op ? ~b : b;
            carry    <= op;
            cnt      <= '0;
            res_sh   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {sum_bit, res_sh[WIDTH-1:1]};
          carry  <= carry_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            // At the MSB, carry holds carry-in and carry_next the carry-out.
            s         <= {sum_bit, res_sh[WIDTH-1:1]};
            c         <= carry_next;
            ovf       <= carry ^ carry_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Results stay on s/c/ovf after the drain until the next completion.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl: directed and swept checks of the serial adder
// at WIDTH=8 and WIDTH=2.
module tb_serial_addsub_ctrl;

  logic       clk;
  logic       rst;

  logic       in_valid8, in_ready8, op8, out_valid8, out_ready8, c8, ovf8, busy8;
  logic [7:0] a8, b8, s8;

  logic       in_valid2, in_ready2, op2, out_valid2, out_ready2, c2, ovf2, busy2;
  logic [1:0] a2, b2, s2;

  int tests_run;
  int tests_failed;

  serial_addsub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .s(s8), .c(c8), .ovf(ovf8), .busy(busy8)
  );

  serial_addsub_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .op(op2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .s(s2), .c(c2), .ovf(ovf2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 transaction. stall = cycles out_ready stays low once valid;
  // noise drives junk operands with in_valid high during RUN, DONE and the drain.
  task automatic do8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic top, input logic [7:0] es, input logic ec,
                     input logic eovf, input int stall, input bit noise);
    int w;
    int lat;
    w = 0;
    while (!in_ready8 && w < 20) begin
      tick();
      w++;
    end
    check({tag, ".in_ready"}, 32'(in_ready8), 32'd1);
    in_valid8  = 1'b1;
    a8         = ta;
    b8         = tb;
    op8        = top;
    out_ready8 = (stall == 0);
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      if (noise) begin
        in_valid8 = 1'b1;
        a8        = 8'hA5;
        b8        = 8'h3C;
        check({tag, ".run_in_ready"}, 32'(in_ready8), 32'd0);
      end
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd8);
    check({tag, ".s"}, 32'(s8), 32'(es));
    check({tag, ".c"}, 32'(c8), 32'(ec));
    check({tag, ".ovf"}, 32'(ovf8), 32'(eovf));
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, ".hold_valid"}, 32'(out_valid8), 32'd1);
      check({tag, ".hold_s"}, 32'({s8, c8, ovf8}), 32'({es, ec, eovf}));
      if (noise) check({tag, ".done_in_ready"}, 32'(in_ready8), 32'd0);
    end
    out_ready8 = 1'b1;
    tick();
    check({tag, ".drain_valid"}, 32'(out_valid8), 32'd0);
    check({tag, ".drain_in_ready"}, 32'(in_ready8), 32'd1);
    if (noise) check({tag, ".not_accepted"}, 32'(busy8), 32'd0);
    in_valid8 = 1'b0;
    $display("[TB] w8 %s a=%02h b=%02h op=%0d -> s=%02h c=%0d ovf=%0d lat=%0d",
             tag, ta, tb, top, s8, c8, ovf8, lat);
  endtask

  // One WIDTH=2 transaction with the consumer always ready.
  task automatic do2(input logic [1:0] ta, input logic [1:0] tb, input logic top,
                     input logic [1:0] es, input logic ec, input logic eovf);
    int lat;
    check("w2.in_ready", 32'(in_ready2), 32'd1);
    in_valid2  = 1'b1;
    a2         = ta;
    b2         = tb;
    op2        = top;
    out_ready2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 20) begin
      tick();
      lat++;
    end
    check("w2.latency", 32'(lat), 32'd2);
    check("w2.result", 32'({s2, c2, ovf2}), 32'({es, ec, eovf}));
    tick();
    check("w2.drain", 32'({out_valid2, in_ready2}), 32'b01);
    $display("[TB] w2 a=%0d b=%0d op=%0d -> s=%0d c=%0d ovf=%0d lat=%0d",
             ta, tb, top, s2, c2, ovf2, lat);
  endtask

  initial begin
    logic [7:0] ra, rb, rbx;
    logic       rop;
    logic [8:0] tot8;
    logic [1:0] bx2;
    logic [2:0] tot2;
    logic       ev;

    tests_run    = 0;
    tests_failed = 0;
    rst        = 1'b1;
    in_valid8  = 1'b0; a8 = '0; b8 = '0; op8 = 1'b0; out_ready8 = 1'b0;
    in_valid2  = 1'b0; a2 = '0; b2 = '0; op2 = 1'b0; out_ready2 = 1'b0;
    tick();
    tick();
    check("reset.in_ready", 32'(in_ready8), 32'd1);
    check("reset.out_valid", 32'(out_valid8), 32'd0);
    check("reset.s_c_ovf", 32'({s8, c8, ovf8}), 32'd0);
    check("reset.busy", 32'(busy8), 32'd0);
    rst = 1'b0;
    tick();

    // Directed vectors, hand-computed.
    do8("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0, 1'b0);
    do8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    do8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1'b0);
    do8("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 0, 1'b0);
    do8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0, 1'b0);
    // Backpressure with ignored in_valid pulses during RUN, DONE and the drain.
    do8("bp_33_11", 8'h33, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0, 5, 1'b1);

    // Asynchronous reset three cycles into a run.
    in_valid8  = 1'b1; a8 = 8'h55; b8 = 8'h22; op8 = 1'b0; out_ready8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick();
    tick();
    tick();
    check("rstmid.busy_before", 32'(busy8), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid.in_ready", 32'(in_ready8), 32'd1);
    check("rstmid.outputs", 32'({out_valid8, s8, c8, ovf8, busy8}), 32'd0);
    $display("[TB] w8 reset mid-run -> in_ready=%0d busy=%0d", in_ready8, busy8);
    #2 rst = 1'b0;
    tick();
    do8("after_rst_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0, 1'b0);

    // Random sweep at WIDTH=8 with random consumer stalls.
    for (int i = 0; i < 300; i++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rop  = 1'($urandom_range(0, 1));
      rbx  = rop ? ~rb : rb;
      tot8 = {1'b0, ra} + {1'b0, rbx} + 9'(rop);
      if (rop) ev = (ra[7] != rb[7]) && (tot8[7] != ra[7]);
      else     ev = (ra[7] == rb[7]) && (tot8[7] != ra[7]);
      do8("rand", ra, rb, rop, tot8[7:0], tot8[8], ev, $urandom_range(0, 3), 1'b0);
    end

    // Exhaustive sweep at WIDTH=2.
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int io = 0; io < 2; io++) begin
          bx2  = (io == 1) ? ~2'(ib) : 2'(ib);
          tot2 = {1'b0, 2'(ia)} + {1'b0, bx2} + 3'(io);
          if (io == 1) ev = (2'(ia) >> 1 != 2'(ib) >> 1) && (tot2[1] != 2'(ia) >> 1);
          else         ev = (2'(ia) >> 1 == 2'(ib) >> 1) && (tot2[1] != 2'(ia) >> 1);
          do2(2'(ia), 2'(ib), 1'(io), tot2[1:0], tot2[2], ev);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
